systolic_skew_feeder: RTL
=========================

Name: systolic_skew_feeder

Overview:
- Upstream edge stage for the N x N systolic array of PE instances.
- Buffers one tile of A (N x N) and B (N x N) through a valid/ready load port.
- Streams the tile into the array's west edge (a_in of column-0 PEs) and north edge (b_in of row-0 PEs), with diagonal skew and zero padding.
- Follows the stream with a drain window so the array can flush, then signals tile completion.

Parameters:
- WIDTH, 8, signed element width; must match the PE WIDTH.
- N, 4, array dimension; the tile is N x N. Legal range is N >= 2.
- DRAIN_CYCLES, 8, number of zero-output cycles after the feed window; default is 2*N. Legal range is >= 1.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous abort; returns the block to LOAD.
- load_valid  input  1  load beat valid.
- load_ready  output  1  block can accept a load beat.
- load_a  input  N*WIDTH  column k of A; slice [i*WIDTH +: WIDTH] = A[i][k].
- load_b  input  N*WIDTH  row k of B; slice [j*WIDTH +: WIDTH] = B[k][j].
- a_edge  output  N*WIDTH  west-edge operands; slice i drives a_in of PE(i,0).
- b_edge  output  N*WIDTH  north-edge operands; slice j drives b_in of PE(0,j).
- feed_valid  output  1  high during the 2N-1 cycle skewed feed window.
- busy  output  1  high in FEED or DRAIN.
- tile_done  output  1  one-cycle pulse on the last DRAIN cycle.

Behaviour:
- Reset (rst high, asynchronous):
  - State = LOAD, beat counter = 0, feed counter = 0.
  - a_edge = 0, b_edge = 0, feed_valid = 0, busy = 0, tile_done = 0, load_ready = 1.
  - Buffer contents are don't-care.
- States are LOAD, FEED and DRAIN. All outputs are registered, except that load_ready = (state == LOAD).
- LOAD:
  - A handshake is load_valid && load_ready at the rising edge.
  - Beat k (k = 0..N-1, from the beat counter) writes A column k and B row k.
  - Gaps in load_valid are allowed. Data on non-handshake cycles is ignored.
  - After beat N-1 is accepted, the state becomes FEED on that same edge. feed_valid and busy are high in the next cycle.
- FEED, lasting exactly 2N-1 cycles, indexed t = 0..2N-2:
  - a_edge slice i = A[i][t-i] if 0 <= t-i < N, else 0.
  - b_edge slice j = B[t-j][j] if 0 <= t-j < N, else 0.
  - load_ready = 0.
  - After cycle t = 2N-2 the state becomes DRAIN.
- DRAIN, lasting DRAIN_CYCLES cycles:
  - a_edge = 0, b_edge = 0, feed_valid = 0, busy = 1.
  - tile_done = 1 only in the final DRAIN cycle.
  - The following cycle is LOAD with busy = 0 and load_ready = 1.
- Tile-to-tile spacing: the first beat of the next tile can be accepted in the first LOAD cycle. There is no extra bubble.
- Outputs outside FEED: a_edge and b_edge are 0 whenever feed_valid = 0, so the PEs accumulate no garbage.
- Width rule: operands pass through bit-exact as signed WIDTH. There is no arithmetic, saturation or sign change.
- clear (synchronous, any state):
  - On the next edge: state = LOAD, counters = 0, a_edge = 0, b_edge = 0.
  - feed_valid, busy and tile_done go to 0. No tile_done pulse is emitted.
  - A load handshake in the same cycle as clear is discarded.
  - If clear is asserted during LOAD, partially loaded beats are discarded and the beat counter restarts at 0.
- Reset mid-FEED or mid-DRAIN: all outputs drop to their reset values immediately (asynchronous), with no tile_done.
- load_valid held high during FEED or DRAIN has no effect and does not stall the feed.

Test Plan:
- Basic skew (N=4, A[i][k] = 10i+k+1, B[k][j] = 10k+j+1, four back-to-back beats):
  - feed_valid is high exactly 7 cycles, starting the cycle after beat 3.
  - At t=0: a_edge = {0,0,0,1}, b_edge = {0,0,0,1} (slice 3..0).
  - At t=3: a_edge slices 0..3 = 4, 13, 22, 31; b_edge slices 0..3 = 31, 22, 13, 4.
  - At t=6: a_edge slice 3 = 34, other slices 0; b_edge slice 3 = 34, other slices 0.
- Drain and done:
  - After t=6, 8 cycles of zeros with busy=1 and feed_valid=0.
  - tile_done pulses in the 8th of those cycles; load_ready=1 in the next cycle.
- Gapped load:
  - load_valid toggles 1,0,0,1,1,0,1 and load_b changes during the gaps.
  - Only the 4 handshaken beats are stored, and the feed matches the basic-skew values.
- Signed passthrough:
  - All A and B entries are -128 (8'h80).
  - Every non-padded slot shows 8'h80 and padded slots show 8'h00.
- Back-pressure ignored:
  - load_valid is held at 1 through FEED and DRAIN.
  - load_ready stays 0, buffer contents are unchanged, and the next tile is accepted starting in the first LOAD cycle.
- Abort:
  - Assert clear at FEED t=2: the next cycle has all outputs 0, load_ready=1, and no tile_done.
  - Assert rst asynchronously in DRAIN: outputs are 0 without waiting for a clock edge.
  - A new tile then feeds correctly.

Source files
------------

// File: rtl/systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// systolic_skew_feeder
//
// Upstream edge stage for an N x N systolic array. One tile of A and B is
// buffered through a valid/ready load port (one column of A and one row of B
// per beat). The tile is then streamed into the array's west edge (A) and
// north edge (B) with a one-cycle-per-lane diagonal skew and zero padding.
// A zero-output drain window follows so the array can flush. tile_done
// pulses on the last drain cycle.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   clear       synchronous abort back to LOAD (no tile_done is emitted)
//   load_valid  load beat valid
//   load_ready  high while in LOAD (combinational from the state register)
//   load_a      column k of A; slice i = A[i][k]
//   load_b      row k of B;    slice j = B[k][j]
//   a_edge      west-edge operands; slice i feeds a_in of PE(i,0)
//   b_edge      north-edge operands; slice j feeds b_in of PE(0,j)
//   feed_valid  high during the 2N-1 cycle skewed feed window
//   busy        high in FEED or DRAIN
//   tile_done   one-cycle pulse in the final DRAIN cycle
// -----------------------------------------------------------------------------
module systolic_skew_feeder #(
  parameter int WIDTH        = 8,
  parameter int N            = 4,
  parameter int DRAIN_CYCLES = 2 * N
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [N*WIDTH-1:0] load_a,
  input  logic [N*WIDTH-1:0] load_b,
  output logic [N*WIDTH-1:0] a_edge,
  output logic [N*WIDTH-1:0] b_edge,
  output logic               feed_valid,
  output logic               busy,
  output logic               tile_done
);

  // Counter widths: beat 0..N-1, feed index 0..2N-2, drain index 0..D-1.
  localparam int BW = $clog2(N);
  localparam int TW = $clog2(2 * N - 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  localparam logic [BW-1:0] BEAT_LAST  = BW'(N - 1);
  localparam logic [TW-1:0] FEED_LAST  = TW'(2 * N - 2);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] beat,  beat_nxt;
  logic [TW-1:0] t_idx, t_nxt;
  logic [DW-1:0] d_idx, d_nxt;

  // Next values of the registered outputs.
  logic               show;      // next cycle presents feed slot t_nxt
  logic               fv_nxt;
  logic               busy_nxt;
  logic               done_nxt;
  logic [N*WIDTH-1:0] a_nxt;
  logic [N*WIDTH-1:0] b_nxt;
  logic               wr_en;

  // Tile buffers: a_buf[i][k] = A[i][k], b_buf[k][j] = B[k][j].
  logic [WIDTH-1:0] a_buf [N][N];
  logic [WIDTH-1:0] b_buf [N][N];

  assign load_ready = (state == S_LOAD);

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    t_nxt     = t_idx;
    d_nxt     = d_idx;
    show      = 1'b0;
    fv_nxt    = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    wr_en     = 1'b0;

    if (clear) begin
      // Abort wins over everything, including a same-cycle load handshake.
      state_nxt = S_LOAD;
      beat_nxt  = '0;
      t_nxt     = '0;
      d_nxt     = '0;
    end else begin
      unique case (state)
        S_LOAD: begin
          if (load_valid) begin
            wr_en = 1'b1;
            if (beat == BEAT_LAST) begin
              // Slot 0 only needs A[0][0] and B[0][0], written on beat 0,
              // so the first feed slot can be registered on this same edge.
              state_nxt = S_FEED;
              beat_nxt  = '0;
              t_nxt     = '0;
              show      = 1'b1;
              fv_nxt    = 1'b1;
              busy_nxt  = 1'b1;
            end else begin
              beat_nxt = beat + 1'b1;
            end
          end
        end

        S_FEED: begin
          busy_nxt = 1'b1;
          if (t_idx == FEED_LAST) begin
            state_nxt = S_DRAIN;
            d_nxt     = '0;
            done_nxt  = (DRAIN_CYCLES == 1);
          end else begin
            t_nxt  = t_idx + 1'b1;
            show   = 1'b1;
            fv_nxt = 1'b1;
          end
        end

        S_DRAIN: begin
          if (d_idx == DRAIN_LAST) begin
            state_nxt = S_LOAD;
            d_nxt     = '0;
          end else begin
            d_nxt    = d_idx + 1'b1;
            busy_nxt = 1'b1;
            done_nxt = ((d_idx + 1'b1) == DRAIN_LAST);
          end
        end

        default: begin
          state_nxt = S_LOAD;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Skew selection: lane i of the west edge carries A[i][t-i], lane j of the
  // north edge carries B[t-j][j]; anything outside the tile is zero padding.
  // ---------------------------------------------------------------------------
  always_comb begin
    a_nxt = '0;
    b_nxt = '0;
    if (show) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (i + k == int'(t_nxt)) begin
            a_nxt[i*WIDTH +: WIDTH] = a_buf[i][k];
            b_nxt[i*WIDTH +: WIDTH] = b_buf[k][i];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State, counters and registered outputs.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_LOAD;
      beat       <= '0;
      t_idx      <= '0;
      d_idx      <= '0;
      a_edge     <= '0;
      b_edge     <= '0;
      feed_valid <= 1'b0;
      busy       <= 1'b0;
      tile_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      beat       <= beat_nxt;
      t_idx      <= t_nxt;
      d_idx      <= d_nxt;
      a_edge     <= a_nxt;
      b_edge     <= b_nxt;
      feed_valid <= fv_nxt;
      busy       <= busy_nxt;
      tile_done  <= done_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Tile buffers.
  // NOTE: the buffers carry no reset; every entry is rewritten by a full load
  // before it is ever read, so a reset would only add routing.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < N; i++) begin
        a_buf[i][beat] <= load_a[i*WIDTH +: WIDTH];
        b_buf[beat][i] <= load_b[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule
